line_req_arbiter: RTL and testbench



---
 rtl/line_req_arbiter_if.sv | 32 +++
 rtl/line_req_arbiter.sv | 190 +++++++++++++++++++
 tb/tb_line_req_arbiter.sv | 338 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/line_req_arbiter_if.sv
// Cache-line request/response bundle between a requester and the
// arbiter, and between the arbiter and the downstream memory port.
interface line_req_arbiter_if #(
  parameter int AWIDTH = 32,
  parameter int LWIDTH = 128,
  parameter int MWIDTH = LWIDTH / 8
);
  logic              wstart_rq;
  logic [AWIDTH-1:0] win_addr;
  logic [LWIDTH-1:0] in_wdata;
  logic [MWIDTH-1:0] in_mask;
  logic              finish_wresp;
  logic              rstart_rq;
  logic [AWIDTH-1:0] rin_addr;
  logic [LWIDTH-1:0] rdat_m_data;
  logic              rdat_m_valid;
  logic              finish_mrd;

  modport master (
    output wstart_rq, win_addr, in_wdata, in_mask,
    output rstart_rq, rin_addr,
    input  finish_wresp, rdat_m_data,
    input  rdat_m_valid, finish_mrd
  );

  modport slave (
    input  wstart_rq, win_addr, in_wdata, in_mask,
    input  rstart_rq, rin_addr,
    output finish_wresp, rdat_m_data,
    output rdat_m_valid, finish_mrd
  );
endinterface

// File: rtl/line_req_arbiter.sv
// Round-robin arbiter sharing one cache-line memory port between
// the D-cache line engine (r0) and the UART loader (r1).
module line_req_arbiter #(
  parameter int AWIDTH = 32,
  parameter int LWIDTH = 128,
  parameter int MWIDTH = LWIDTH / 8
) (
  input  logic               clk,
  input  logic               rst_n,
  line_req_arbiter_if.slave  r0,
  line_req_arbiter_if.slave  r1,
  line_req_arbiter_if.master m,
  output logic               busy,
  output logic               grant_id,
  output logic               proto_err
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_W, WAIT_R} state_e;
  state_e state_q, state_d;

  logic [1:0]             wreq, rreq;
  logic [1:0][AWIDTH-1:0] waddr_in, raddr_in;
  logic [1:0][LWIDTH-1:0] wdata_in;
  logic [1:0][MWIDTH-1:0] wmask_in;

  assign wreq     = {r1.wstart_rq, r0.wstart_rq};
  assign rreq     = {r1.rstart_rq, r0.rstart_rq};
  assign waddr_in = {r1.win_addr, r0.win_addr};
  assign raddr_in = {r1.rin_addr, r0.rin_addr};
  assign wdata_in = {r1.in_wdata, r0.in_wdata};
  assign wmask_in = {r1.in_mask, r0.in_mask};

  logic [1:0]             wp_q, wp_d, rp_q, rp_d;
  logic [1:0][AWIDTH-1:0] waddr_q, raddr_q;
  logic [1:0][LWIDTH-1:0] wdata_q;
  logic [1:0][MWIDTH-1:0] wmask_q;

  logic              grant_q, grant_d, wr_q, wr_d;
  logic              busy_q, busy_d, err_q, err_d;
  logic              settle_q, settle_d;
  logic              mws_q, mws_d, mrs_q, mrs_d;
  logic [AWIDTH-1:0] mwa_q, mwa_d, mra_q, mra_d;
  logic [LWIDTH-1:0] mwd_q, mwd_d;
  logic [MWIDTH-1:0] mwm_q, mwm_d;
  logic [1:0]        fw_q, fw_d, fr_q, fr_d, rv_q, rv_d;
  logic [1:0][LWIDTH-1:0] rd_q, rd_d;

  logic [1:0] has, clr_w, clr_r, ld_w, ld_r;
  logic       sel, sel_w, go, drop;
  logic       fin_w, fin_r, val_r;

  // settle_q holds off a new issue for one cycle after each finish
  assign has   = wp_q | rp_q;
  assign sel   = (&has) ? ~grant_q : has[1];
  assign sel_w = wp_q[sel];
  assign go    = (state_q == IDLE) && (|has) && !settle_q;
  assign fin_w = (state_q == WAIT_W) && m.finish_wresp;
  assign fin_r = (state_q == WAIT_R) && m.finish_mrd;
  assign val_r = (state_q == WAIT_R) && m.rdat_m_valid;

  always_comb begin
    clr_w = '0;
    clr_r = '0;
    if (state_q == ISSUE) begin
      clr_w[grant_q] = wr_q;
      clr_r[grant_q] = ~wr_q;
    end
    ld_w = wreq & (~wp_q | clr_w);
    ld_r = rreq & (~rp_q | clr_r);
    drop = (|(wreq & ~ld_w)) | (|(rreq & ~ld_r));
    wp_d = (wp_q & ~clr_w) | ld_w;
    rp_d = (rp_q & ~clr_r) | ld_r;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (go) state_d = ISSUE;
      ISSUE:   state_d = wr_q ? WAIT_W : WAIT_R;
      WAIT_W:  if (m.finish_wresp) state_d = IDLE;
      WAIT_R:  if (m.finish_mrd) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mws_d   = go & sel_w;
    mrs_d   = go & ~sel_w;
    grant_d = go ? sel : grant_q;
    wr_d    = go ? sel_w : wr_q;
    mwa_d   = mwa_q;
    mwd_d   = mwd_q;
    mwm_d   = mwm_q;
    mra_d   = mra_q;
    if (mws_d) begin
      mwa_d = waddr_q[sel];
      mwd_d = wdata_q[sel];
      mwm_d = wmask_q[sel];
    end
    if (mrs_d) mra_d = raddr_q[sel];
    fw_d = '0;
    fr_d = '0;
    rv_d = '0;
    rd_d = '0;
    fw_d[grant_q] = fin_w;
    fr_d[grant_q] = fin_r;
    rv_d[grant_q] = val_r;
    if (val_r) rd_d[grant_q] = m.rdat_m_data;
    busy_d   = (state_d != IDLE);
    settle_d = fin_w | fin_r;
    err_d    = err_q | drop
             | (m.finish_wresp & (state_q != WAIT_W))
             | ((m.finish_mrd | m.rdat_m_valid)
                & (state_q != WAIT_R));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wp_q     <= '0;
      rp_q     <= '0;
      waddr_q  <= '0;
      raddr_q  <= '0;
      wdata_q  <= '0;
      wmask_q  <= '0;
      grant_q  <= 1'b0;
      wr_q     <= 1'b0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
      settle_q <= 1'b0;
      mws_q    <= 1'b0;
      mrs_q    <= 1'b0;
      mwa_q    <= '0;
      mwd_q    <= '0;
      mwm_q    <= '0;
      mra_q    <= '0;
      fw_q     <= '0;
      fr_q     <= '0;
      rv_q     <= '0;
      rd_q     <= '0;
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
      for (int i = 0; i < 2; i++) begin
        if (ld_w[i]) begin
          waddr_q[i] <= waddr_in[i];
          wdata_q[i] <= wdata_in[i];
          wmask_q[i] <= wmask_in[i];
        end
        if (ld_r[i]) raddr_q[i] <= raddr_in[i];
      end
      grant_q  <= grant_d;
      wr_q     <= wr_d;
      busy_q   <= busy_d;
      err_q    <= err_d;
      settle_q <= settle_d;
      mws_q    <= mws_d;
      mrs_q    <= mrs_d;
      mwa_q    <= mwa_d;
      mwd_q    <= mwd_d;
      mwm_q    <= mwm_d;
      mra_q    <= mra_d;
      fw_q     <= fw_d;
      fr_q     <= fr_d;
      rv_q     <= rv_d;
      rd_q     <= rd_d;
    end
  end

  assign m.wstart_rq     = mws_q;
  assign m.win_addr      = mwa_q;
  assign m.in_wdata      = mwd_q;
  assign m.in_mask       = mwm_q;
  assign m.rstart_rq     = mrs_q;
  assign m.rin_addr      = mra_q;
  assign r0.finish_wresp = fw_q[0];
  assign r1.finish_wresp = fw_q[1];
  assign r0.finish_mrd   = fr_q[0];
  assign r1.finish_mrd   = fr_q[1];
  assign r0.rdat_m_valid = rv_q[0];
  assign r1.rdat_m_valid = rv_q[1];
  assign r0.rdat_m_data  = rd_q[0];
  assign r1.rdat_m_data  = rd_q[1];
  assign busy            = busy_q;
  assign grant_id        = grant_q;
  assign proto_err       = err_q;
endmodule

// File: tb/tb_line_req_arbiter.sv
// Bench for line_req_arbiter: directed scenarios plus random traffic,
// every cycle compared against a transaction-level reference model.
module tb_line_req_arbiter;
  localparam int AW = 32;
  localparam int LW = 128;
  localparam int MW = 16;
  localparam logic [LW-1:0] DB = {16'hDEAD, 96'h0, 16'hBEEF};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy, grant_id, proto_err;

  line_req_arbiter_if #(.AWIDTH(AW), .LWIDTH(LW), .MWIDTH(MW)) r0 ();
  line_req_arbiter_if #(.AWIDTH(AW), .LWIDTH(LW), .MWIDTH(MW)) r1 ();
  line_req_arbiter_if #(.AWIDTH(AW), .LWIDTH(LW), .MWIDTH(MW)) m ();

  line_req_arbiter #(.AWIDTH(AW), .LWIDTH(LW), .MWIDTH(MW)) dut (
    .clk(clk), .rst_n(rst_n), .r0(r0), .r1(r1), .m(m),
    .busy(busy), .grant_id(grant_id), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  logic          ws [2];
  logic          rs [2];
  logic [AW-1:0] wa [2];
  logic [AW-1:0] ra [2];
  logic [LW-1:0] wd [2];
  logic [MW-1:0] wm [2];
  logic          m_fw, m_rv, m_fr;
  logic [LW-1:0] m_rd;

  assign r0.wstart_rq = ws[0];
  assign r1.wstart_rq = ws[1];
  assign r0.rstart_rq = rs[0];
  assign r1.rstart_rq = rs[1];
  assign r0.win_addr  = wa[0];
  assign r1.win_addr  = wa[1];
  assign r0.rin_addr  = ra[0];
  assign r1.rin_addr  = ra[1];
  assign r0.in_wdata  = wd[0];
  assign r1.in_wdata  = wd[1];
  assign r0.in_mask   = wm[0];
  assign r1.in_mask   = wm[1];
  assign m.finish_wresp = m_fw;
  assign m.rdat_m_valid = m_rv;
  assign m.finish_mrd   = m_fr;
  assign m.rdat_m_data  = m_rd;

  logic          fw_o [2];
  logic          fr_o [2];
  logic          rv_o [2];
  logic [LW-1:0] rd_o [2];
  assign fw_o[0] = r0.finish_wresp;
  assign fw_o[1] = r1.finish_wresp;
  assign fr_o[0] = r0.finish_mrd;
  assign fr_o[1] = r1.finish_mrd;
  assign rv_o[0] = r0.rdat_m_valid;
  assign rv_o[1] = r1.rdat_m_valid;
  assign rd_o[0] = r0.rdat_m_data;
  assign rd_o[1] = r1.rdat_m_data;

  // Reference model: slots per requester, one in-flight transaction
  bit            pend [2][2];
  logic [AW-1:0] saddr [2][2];
  logic [LW-1:0] sdata [2];
  logic [MW-1:0] smask [2];
  bit            infl;
  int            own, kind, iss_cyc, earliest, cyc;
  bit            e_gnt, e_err, e_busy, e_mw, e_mr, skip_busy;
  logic [AW-1:0] e_wa, e_ra;
  logic [LW-1:0] e_wd;
  logic [MW-1:0] e_wm;
  bit            e_fw [2];
  bit            e_fr [2];
  bit            e_rv [2];
  logic [LW-1:0] e_rd [2];

  int n_chk = 0;
  int n_err = 0;
  bit auto_on = 1'b1;
  int rsp_div = 0;

  task automatic chk(input string tag, input logic [LW-1:0] got,
                     input logic [LW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %0h expected %0h",
               tag, cyc, got, exp);
    end
  endtask

  function automatic logic [LW-1:0] rnd_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic step();
    bit done, go, h0, h1;
    int ir, ik;
    bit inw;
    e_mw = 1'b0;
    e_mr = 1'b0;
    skip_busy = 1'b0;
    ir = 0;
    ik = 0;
    for (int i = 0; i < 2; i++) begin
      e_fw[i] = 1'b0;
      e_fr[i] = 1'b0;
      e_rv[i] = 1'b0;
      e_rd[i] = '0;
    end
    if (!rst_n) begin
      for (int i = 0; i < 2; i++)
        for (int k = 0; k < 2; k++) pend[i][k] = 1'b0;
      infl = 1'b0;
      e_gnt = 1'b0;
      e_err = 1'b0;
      e_busy = 1'b0;
      e_wa = '0;
      e_wd = '0;
      e_wm = '0;
      e_ra = '0;
      earliest = 0;
      cyc++;
      return;
    end
    inw = infl && (cyc > iss_cyc);
    done = 1'b0;
    if (m_fw) begin
      if (inw && kind == 0) begin e_fw[own] = 1'b1; done = 1'b1; end
      else e_err = 1'b1;
    end
    if (m_rv) begin
      if (inw && kind == 1) begin e_rv[own] = 1'b1; e_rd[own] = m_rd; end
      else e_err = 1'b1;
    end
    if (m_fr) begin
      if (inw && kind == 1) begin e_fr[own] = 1'b1; done = 1'b1; end
      else e_err = 1'b1;
    end
    if (done) begin
      infl = 1'b0;
      earliest = cyc + 3;
      skip_busy = 1'b1;
    end
    go = 1'b0;
    h0 = pend[0][0] | pend[0][1];
    h1 = pend[1][0] | pend[1][1];
    if (!infl && (cyc + 1 >= earliest) && (h0 || h1)) begin
      go = 1'b1;
      ir = (h0 && h1) ? (e_gnt ? 0 : 1) : (h1 ? 1 : 0);
      ik = pend[ir][0] ? 0 : 1;
      if (ik == 0) begin
        e_mw = 1'b1;
        e_wa = saddr[ir][0];
        e_wd = sdata[ir];
        e_wm = smask[ir];
      end else begin
        e_mr = 1'b1;
        e_ra = saddr[ir][1];
      end
      e_gnt = (ir == 1);
      own = ir;
      kind = ik;
      infl = 1'b1;
      iss_cyc = cyc + 1;
    end
    for (int i = 0; i < 2; i++) begin
      if (ws[i]) begin
        if (pend[i][0]) e_err = 1'b1;
        else begin
          pend[i][0] = 1'b1;
          saddr[i][0] = wa[i];
          sdata[i] = wd[i];
          smask[i] = wm[i];
        end
      end
      if (rs[i]) begin
        if (pend[i][1]) e_err = 1'b1;
        else begin
          pend[i][1] = 1'b1;
          saddr[i][1] = ra[i];
        end
      end
    end
    if (go) pend[ir][ik] = 1'b0;
    e_busy = infl;
    cyc++;
  endtask

  task automatic compare();
    chk("m_wstart_rq", m.wstart_rq, e_mw);
    chk("m_rstart_rq", m.rstart_rq, e_mr);
    chk("m_win_addr", m.win_addr, e_wa);
    chk("m_in_wdata", m.in_wdata, e_wd);
    chk("m_in_mask", m.in_mask, e_wm);
    chk("m_rin_addr", m.rin_addr, e_ra);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("r%0d_finish_wresp", i), fw_o[i], e_fw[i]);
      chk($sformatf("r%0d_finish_mrd", i), fr_o[i], e_fr[i]);
      chk($sformatf("r%0d_rdat_valid", i), rv_o[i], e_rv[i]);
      chk($sformatf("r%0d_rdat_data", i), rd_o[i], e_rd[i]);
    end
    if (!skip_busy) chk("busy", busy, e_busy);
    chk("grant_id", grant_id, e_gnt);
    chk("proto_err", proto_err, e_err);
  endtask

  task automatic drive_idle();
    for (int i = 0; i < 2; i++) begin
      ws[i] = 1'b0;
      rs[i] = 1'b0;
      wa[i] = $urandom;
      ra[i] = $urandom;
      wd[i] = rnd_line();
      wm[i] = MW'($urandom);
    end
    m_fw = 1'b0;
    m_rv = 1'b0;
    m_fr = 1'b0;
    m_rd = rnd_line();
    if (auto_on && infl && cyc > iss_cyc
        && $urandom_range(0, rsp_div) == 0) begin
      if (kind == 0) m_fw = 1'b1;
      else if (rsp_div == 0) begin
        m_rv = 1'b1;
        m_fr = 1'b1;
        m_rd = DB;
      end else begin
        m_rv = 1'($urandom_range(0, 1));
        m_fr = 1'($urandom_range(0, 1));
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    step();
    #1;
    compare();
    @(negedge clk);
    drive_idle();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    drive_idle();
    ticks(2);
    rst_n = 1'b1;
    tick();

    // single dc write
    ws[0] = 1'b1;
    wa[0] = 32'h0000_1000;
    wm[0] = '0;
    ticks(10);

    // dc write and read in the same cycle
    ws[0] = 1'b1;
    rs[0] = 1'b1;
    ra[0] = 32'h0000_2000;
    ticks(16);

    // both requesters kept pending
    for (int i = 0; i < 2; i++) begin
      ws[i] = 1'b1;
      rs[i] = 1'b1;
    end
    for (int n = 0; n < 30; n++) begin
      tick();
      for (int i = 0; i < 2; i++) begin
        if (!pend[i][0]) ws[i] = 1'b1;
        if (!pend[i][1]) rs[i] = 1'b1;
      end
    end
    ticks(30);

    // duplicate r1 read while it is still pending
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    auto_on = 1'b0;
    ws[0] = 1'b1;
    ticks(4);
    rs[1] = 1'b1;
    ra[1] = 32'h0000_0A00;
    tick();
    rs[1] = 1'b1;
    ra[1] = 32'h0000_0B00;
    tick();
    auto_on = 1'b1;
    ticks(14);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    m_fr = 1'b1;
    ticks(3);

    // reset during a read
    auto_on = 1'b0;
    rs[0] = 1'b1;
    ticks(5);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    m_fr = 1'b1;
    ticks(4);
    auto_on = 1'b1;

    // random traffic
    rsp_div = 2;
    for (int n = 0; n < 3000; n++) begin
      rst_n = ($urandom_range(0, 299) != 0);
      for (int i = 0; i < 2; i++) begin
        ws[i] = ($urandom_range(0, 5) == 0);
        rs[i] = ($urandom_range(0, 5) == 0);
      end
      if ($urandom_range(0, 49) == 0) begin
        case ($urandom_range(0, 2))
          0:       m_fw = 1'b1;
          1:       m_rv = 1'b1;
          default: m_fr = 1'b1;
        endcase
      end
      tick();
    end
    rst_n = 1'b1;
    ticks(20);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
